// File: rtl/sram_like_arbiter.sv
// Two-master SRAM-like port arbiter: fixed priority to the data requester (m1),
// grant held until address accept, in-order ID FIFO routes responses back.
module sram_like_arbiter #(
  parameter int unsigned MAX_OUTS = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_wr,
  input  logic [1:0]  m0_size,
  input  logic [31:0] m0_addr,
  input  logic [3:0]  m0_wstrb,
  input  logic [31:0] m0_wdata,
  output logic        m0_addr_ok,
  output logic        m0_data_ok,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_wr,
  input  logic [1:0]  m1_size,
  input  logic [31:0] m1_addr,
  input  logic [3:0]  m1_wstrb,
  input  logic [31:0] m1_wdata,
  output logic        m1_addr_ok,
  output logic        m1_data_ok,
  output logic [31:0] m1_rdata,
  output logic        s_req,
  output logic        s_wr,
  output logic [1:0]  s_size,
  output logic [31:0] s_addr,
  output logic [3:0]  s_wstrb,
  output logic [31:0] s_wdata,
  input  logic        s_addr_ok,
  input  logic        s_data_ok,
  input  logic [31:0] s_rdata
);

  localparam int unsigned PTR_W = (MAX_OUTS > 1) ? $clog2(MAX_OUTS) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, HOLD0, HOLD1} state_t;

  state_t              state;
  logic [CNT_W-1:0]    count;
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [MAX_OUTS-1:0] ids;

  logic full;
  logic empty;
  logic gnt_vld;
  logic gnt_id;
  logic push;
  logic pop;
  logic head;

  // Grant selection: held grants override priority, new grants only when not full
  always_comb begin
    full    = (count == CNT_W'(MAX_OUTS));
    empty   = (count == '0);
    gnt_vld = 1'b0;
    gnt_id  = 1'b0;
    case (state)
      IDLE: begin
        if (!full && m1_req) begin
          gnt_vld = 1'b1;
          gnt_id  = 1'b1;
        end else if (!full && m0_req) begin
          gnt_vld = 1'b1;
          gnt_id  = 1'b0;
        end
      end
      HOLD0: begin
        gnt_vld = 1'b1;
        gnt_id  = 1'b0;
      end
      HOLD1: begin
        gnt_vld = 1'b1;
        gnt_id  = 1'b1;
      end
      default: begin
        gnt_vld = 1'b0;
        gnt_id  = 1'b0;
      end
    endcase
  end

  // Slave request mux; fields are zero without a grant
  always_comb begin
    s_req   = 1'b0;
    s_wr    = 1'b0;
    s_size  = 2'd0;
    s_addr  = 32'd0;
    s_wstrb = 4'd0;
    s_wdata = 32'd0;
    if (gnt_vld) begin
      if (gnt_id) begin
        s_req   = m1_req & ~full & ~reset;
        s_wr    = m1_wr;
        s_size  = m1_size;
        s_addr  = m1_addr;
        s_wstrb = m1_wstrb;
        s_wdata = m1_wdata;
      end else begin
        s_req   = m0_req & ~full & ~reset;
        s_wr    = m0_wr;
        s_size  = m0_size;
        s_addr  = m0_addr;
        s_wstrb = m0_wstrb;
        s_wdata = m0_wdata;
      end
    end
  end

  assign push = s_req & s_addr_ok;
  assign pop  = s_data_ok & ~empty & ~reset;
  assign head = ids[rd_ptr];

  assign m0_addr_ok = push & ~gnt_id;
  assign m1_addr_ok = push & gnt_id;
  assign m0_data_ok = pop & ~head;
  assign m1_data_ok = pop & head;
  assign m0_rdata   = s_rdata;
  assign m1_rdata   = s_rdata;

  // Grant FSM and ID FIFO state
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      ids    <= '0;
    end else begin
      case (state)
        IDLE:    if (s_req && !s_addr_ok) state <= gnt_id ? HOLD1 : HOLD0;
        HOLD0:   if (s_addr_ok || !m0_req) state <= IDLE;
        HOLD1:   if (s_addr_ok || !m1_req) state <= IDLE;
        default: state <= IDLE;
      endcase
      if (push) begin
        ids[wr_ptr] <= gnt_id;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter: priority, hold, full stall, push/pop, reset.
module tb_sram_like_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_wr, m1_req, m1_wr;
  logic [1:0]  m0_size, m1_size;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        m0_addr_ok, m0_data_ok, m1_addr_ok, m1_data_ok;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_req, s_wr;
  logic [1:0]  s_size;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_addr_ok, s_data_ok;
  logic [31:0] s_rdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sram_like_arbiter #(.MAX_OUTS(2)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_size(m0_size), .m0_addr(m0_addr),
    .m0_wstrb(m0_wstrb), .m0_wdata(m0_wdata), .m0_addr_ok(m0_addr_ok),
    .m0_data_ok(m0_data_ok), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_size(m1_size), .m1_addr(m1_addr),
    .m1_wstrb(m1_wstrb), .m1_wdata(m1_wdata), .m1_addr_ok(m1_addr_ok),
    .m1_data_ok(m1_data_ok), .m1_rdata(m1_rdata),
    .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_addr(s_addr),
    .s_wstrb(s_wstrb), .s_wdata(s_wdata),
    .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata)
  );

  // Advance one cycle; inputs change 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_req = 0; m0_wr = 0; m0_size = 0; m0_addr = 0; m0_wstrb = 0; m0_wdata = 0;
    m1_req = 0; m1_wr = 0; m1_size = 0; m1_addr = 0; m1_wstrb = 0; m1_wdata = 0;
    s_addr_ok = 0; s_data_ok = 0; s_rdata = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1;
    tick(); tick();
    reset = 0;
    #1;
    checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL rst_s_req: got %b want 0", s_req); end
    checks++; if (s_addr !== 32'd0) begin errors++; $display("FAIL rst_s_addr: got %h want 0", s_addr); end
    s_data_ok = 1; s_addr_ok = 1;
    #1;
    checks++; if ({m0_data_ok, m1_data_ok} !== 2'b00) begin errors++; $display("FAIL rst_stray_data_ok: got %b want 00", {m0_data_ok, m1_data_ok}); end
    checks++; if ({m0_addr_ok, m1_addr_ok} !== 2'b00) begin errors++; $display("FAIL rst_addr_ok: got %b want 00", {m0_addr_ok, m1_addr_ok}); end
    tick();
    clear_inputs();
  endtask

  task automatic test_single_read();
    m1_req = 1; m1_size = 2; m1_addr = 32'h1000; s_addr_ok = 1;
    #1;
    checks++; if (s_req !== 1'b1) begin errors++; $display("FAIL t1_s_req: got %b want 1", s_req); end
    checks++; if (s_addr !== 32'h1000) begin errors++; $display("FAIL t1_s_addr: got %h want 00001000", s_addr); end
    checks++; if (s_size !== 2'd2) begin errors++; $display("FAIL t1_s_size: got %0d want 2", s_size); end
    checks++; if ({m0_addr_ok, m1_addr_ok} !== 2'b01) begin errors++; $display("FAIL t1_addr_ok: got %b want 01", {m0_addr_ok, m1_addr_ok}); end
    tick();
    clear_inputs();
    #1;
    checks++; if ({m0_data_ok, m1_data_ok} !== 2'b00) begin errors++; $display("FAIL t1_c1_data_ok: got %b want 00", {m0_data_ok, m1_data_ok}); end
    tick();
    s_data_ok = 1; s_rdata = 32'hDEADBEEF;
    #1;
    checks++; if ({m0_data_ok, m1_data_ok} !== 2'b01) begin errors++; $display("FAIL t1_data_ok: got %b want 01", {m0_data_ok, m1_data_ok}); end
    checks++; if (m1_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL t1_rdata: got %h want deadbeef", m1_rdata); end
    tick();
    clear_inputs();
  endtask

  task automatic test_priority();
    m0_req = 1; m0_addr = 32'h2000; m1_req = 1; m1_addr = 32'h3000; s_addr_ok = 1;
    #1;
    checks++; if (s_addr !== 32'h3000) begin errors++; $display("FAIL t2_c0_s_addr: got %h want 00003000", s_addr); end
    checks++; if ({m0_addr_ok, m1_addr_ok} !== 2'b01) begin errors++; $display("FAIL t2_c0_addr_ok: got %b want 01", {m0_addr_ok, m1_addr_ok}); end
    tick();
    m1_req = 0;
    #1;
    checks++; if (s_addr !== 32'h2000) begin errors++; $display("FAIL t2_c1_s_addr: got %h want 00002000", s_addr); end
    checks++; if ({m0_addr_ok, m1_addr_ok} !== 2'b10) begin errors++; $display("FAIL t2_c1_addr_ok: got %b want 10", {m0_addr_ok, m1_addr_ok}); end
    tick();
    clear_inputs();
    s_data_ok = 1; s_rdata = 32'hAAAA0001;
    #1;
    checks++; if ({m0_data_ok, m1_data_ok} !== 2'b01) begin errors++; $display("FAIL t2_respA: got %b want 01", {m0_data_ok, m1_data_ok}); end
    tick();
    s_rdata = 32'hBBBB0002;
    #1;
    checks++; if ({m0_data_ok, m1_data_ok} !== 2'b10) begin errors++; $display("FAIL t2_respB: got %b want 10", {m0_data_ok, m1_data_ok}); end
    checks++; if (m0_rdata !== 32'hBBBB0002) begin errors++; $display("FAIL t2_rdataB: got %h want bbbb0002", m0_rdata); end
    tick();
    clear_inputs();
  endtask

  task automatic test_hold();
    m0_req = 1; m0_wr = 1; m0_addr = 32'h4000; m0_wstrb = 4'hF; m0_wdata = 32'h12345678;
    #1;
    checks++; if (s_addr !== 32'h4000) begin errors++; $display("FAIL t3_c0_s_addr: got %h want 00004000", s_addr); end
    checks++; if (m0_addr_ok !== 1'b0) begin errors++; $display("FAIL t3_c0_addr_ok: got %b want 0", m0_addr_ok); end
    tick();
    m1_req = 1; m1_addr = 32'h5000;
    for (int c = 1; c <= 2; c++) begin
      #1;
      checks++; if (s_addr !== 32'h4000) begin errors++; $display("FAIL t3_hold_s_addr c%0d: got %h want 00004000", c, s_addr); end
      checks++; if ({s_wr, s_wstrb, s_wdata} !== {1'b1, 4'hF, 32'h12345678}) begin errors++; $display("FAIL t3_hold_wfields c%0d: got %h want 1f12345678", c, {s_wr, s_wstrb, s_wdata}); end
      tick();
    end
    s_addr_ok = 1;
    #1;
    checks++; if ({m0_addr_ok, m1_addr_ok} !== 2'b10) begin errors++; $display("FAIL t3_accept: got %b want 10", {m0_addr_ok, m1_addr_ok}); end
    tick();
    m0_req = 0; m0_wr = 0;
    #1;
    checks++; if (s_addr !== 32'h5000) begin errors++; $display("FAIL t3_m1_s_addr: got %h want 00005000", s_addr); end
    checks++; if ({m0_addr_ok, m1_addr_ok} !== 2'b01) begin errors++; $display("FAIL t3_m1_accept: got %b want 01", {m0_addr_ok, m1_addr_ok}); end
    tick();
    clear_inputs();
    s_data_ok = 1;
    #1;
    checks++; if ({m0_data_ok, m1_data_ok} !== 2'b10) begin errors++; $display("FAIL t3_resp0: got %b want 10", {m0_data_ok, m1_data_ok}); end
    tick();
    #1;
    checks++; if ({m0_data_ok, m1_data_ok} !== 2'b01) begin errors++; $display("FAIL t3_resp1: got %b want 01", {m0_data_ok, m1_data_ok}); end
    tick();
    clear_inputs();
  endtask

  task automatic test_full();
    m1_req = 1; m1_addr = 32'h6000; s_addr_ok = 1;
    tick();
    m1_req = 0; m0_req = 1; m0_addr = 32'h7000;
    tick();
    m0_req = 0; m1_req = 1; m1_addr = 32'h8000;
    #1;
    checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL t4_full_s_req: got %b want 0", s_req); end
    checks++; if (m1_addr_ok !== 1'b0) begin errors++; $display("FAIL t4_full_addr_ok: got %b want 0", m1_addr_ok); end
    tick();
    s_data_ok = 1;
    #1;
    checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL t4_pop_s_req: got %b want 0", s_req); end
    checks++; if ({m0_data_ok, m1_data_ok} !== 2'b01) begin errors++; $display("FAIL t4_pop_data_ok: got %b want 01", {m0_data_ok, m1_data_ok}); end
    tick();
    s_data_ok = 0;
    #1;
    checks++; if (s_req !== 1'b1) begin errors++; $display("FAIL t4_resume_s_req: got %b want 1", s_req); end
    checks++; if (s_addr !== 32'h8000) begin errors++; $display("FAIL t4_resume_s_addr: got %h want 00008000", s_addr); end
    checks++; if (m1_addr_ok !== 1'b1) begin errors++; $display("FAIL t4_resume_addr_ok: got %b want 1", m1_addr_ok); end
    tick();
    clear_inputs();
    s_data_ok = 1;
    #1;
    checks++; if ({m0_data_ok, m1_data_ok} !== 2'b10) begin errors++; $display("FAIL t4_drain0: got %b want 10", {m0_data_ok, m1_data_ok}); end
    tick();
    #1;
    checks++; if ({m0_data_ok, m1_data_ok} !== 2'b01) begin errors++; $display("FAIL t4_drain1: got %b want 01", {m0_data_ok, m1_data_ok}); end
    tick();
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    bit q[$];
    bit req_id;
    bit exp_id;
    m0_req = 1; m0_addr = 32'hA000; s_addr_ok = 1;
    tick();
    q.push_back(1'b0);
    for (int i = 0; i < 10; i++) begin
      req_id = (i % 2 == 0);
      m0_req = !req_id; m0_addr = 32'hA000 + 32'(i);
      m1_req = req_id;  m1_addr = 32'hB000 + 32'(i);
      s_addr_ok = 1; s_data_ok = 1; s_rdata = 32'h100 + 32'(i);
      exp_id = q[0];
      #1;
      checks++; if ({m0_addr_ok, m1_addr_ok} !== {!req_id, req_id}) begin errors++; $display("FAIL t5_addr_ok i%0d: got %b want %b", i, {m0_addr_ok, m1_addr_ok}, {!req_id, req_id}); end
      checks++; if ({m0_data_ok, m1_data_ok} !== {!exp_id, exp_id}) begin errors++; $display("FAIL t5_data_ok i%0d: got %b want %b", i, {m0_data_ok, m1_data_ok}, {!exp_id, exp_id}); end
      checks++; if ((exp_id ? m1_rdata : m0_rdata) !== 32'h100 + 32'(i)) begin errors++; $display("FAIL t5_rdata i%0d: got %h want %h", i, exp_id ? m1_rdata : m0_rdata, 32'h100 + 32'(i)); end
      void'(q.pop_front());
      q.push_back(req_id);
      tick();
    end
    clear_inputs();
    s_data_ok = 1;
    exp_id = q[0];
    #1;
    checks++; if ({m0_data_ok, m1_data_ok} !== {!exp_id, exp_id}) begin errors++; $display("FAIL t5_drain: got %b want %b", {m0_data_ok, m1_data_ok}, {!exp_id, exp_id}); end
    tick();
    #1;
    checks++; if ({m0_data_ok, m1_data_ok} !== 2'b00) begin errors++; $display("FAIL t5_empty: got %b want 00", {m0_data_ok, m1_data_ok}); end
    tick();
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    m1_req = 1; m1_addr = 32'hC000; s_addr_ok = 1;
    tick();
    m1_addr = 32'hC004; s_addr_ok = 0;
    tick();
    reset = 1;
    tick();
    reset = 0; m1_req = 0; m0_req = 1; m0_addr = 32'h9000; s_data_ok = 1;
    #1;
    checks++; if (s_addr !== 32'h9000) begin errors++; $display("FAIL t6_idle_s_addr: got %h want 00009000", s_addr); end
    checks++; if (s_req !== 1'b1) begin errors++; $display("FAIL t6_s_req: got %b want 1", s_req); end
    checks++; if ({m0_data_ok, m1_data_ok} !== 2'b00) begin errors++; $display("FAIL t6_stray_data_ok: got %b want 00", {m0_data_ok, m1_data_ok}); end
    tick();
    s_data_ok = 0; s_addr_ok = 1;
    #1;
    checks++; if (m0_addr_ok !== 1'b1) begin errors++; $display("FAIL t6_accept: got %b want 1", m0_addr_ok); end
    tick();
    clear_inputs();
    s_data_ok = 1;
    #1;
    checks++; if ({m0_data_ok, m1_data_ok} !== 2'b10) begin errors++; $display("FAIL t6_resp: got %b want 10", {m0_data_ok, m1_data_ok}); end
    tick();
    clear_inputs();
  endtask

  initial begin
    reset = 1;
    clear_inputs();
    #1;
    test_reset();
    test_single_read();
    test_priority();
    test_hold();
    test_full();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
